cmos_half_adder_reg: RTL and testbench

- WIDTH-bit bitwise half-adder slice: per bit, sum = a XOR b and carry = a AND b.
- Results are captured in an output register with a valid flag.
- The combinational core is a transistor-level CMOS network (nmos/pmos switch primitives), so this block is the reference for switch-level gate cells in the datapath library.
- Feeds downstream adder/compare logic that needs registered per-bit sum/carry.

---
 rtl/cmos_half_adder_reg.sv | 121 ++++++++++++
 tb/tb_cmos_half_adder_reg.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cmos_half_adder_reg.sv
// cmos_half_adder_reg: WIDTH-bit bitwise half-adder with a registered result and valid flag.
//
// Each bit slice computes sum = a ^ b and carry = a & b independently; there is no carry
// propagation between slices. The result is captured one cycle after in_valid.
//
// Build option:
//   SWITCH_LEVEL_EN  defined   -> combinational core is a transistor-level CMOS network built
//                                 from nmos/pmos switch primitives (gate/switch-level sim).
//                    undefined -> core uses behavioural ^ and & (synthesis, fast sim).
//   Ports, latency, reset and valid behaviour are identical in both builds.
//
// Parameters:
//   WIDTH      number of independent bit slices (1..32)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; has priority over in_valid
//   in_valid   qualifies a and b this cycle
//   a, b       operands
//   sum        registered per-bit a ^ b
//   carry      registered per-bit a & b
//   out_valid  high for one cycle when sum/carry hold a new result

module cmos_half_adder_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;

`ifdef SWITCH_LEVEL_EN

  supply1 vdd;
  supply0 gnd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    wire nand_ab, nand_ab_mid;   // NAND2(a,b)
    wire and_ab;                 // AND2(a,b), shared with carry
    wire nor_ab, nor_ab_mid;     // NOR2(a,b)
    wire or_ab;                  // OR2(a,b)
    wire nand_n;                 // INV(AND2(a,b))
    wire nand_x, nand_x_mid;     // NAND2(or_ab, nand_n)
    wire xor_ab;                 // AND2(or_ab, nand_n) = a ^ b

    // NAND2(a,b): parallel pull-ups, series pull-downs
    pmos p_nand_a (nand_ab, vdd, a[i]);
    pmos p_nand_b (nand_ab, vdd, b[i]);
    nmos n_nand_a (nand_ab, nand_ab_mid, a[i]);
    nmos n_nand_b (nand_ab_mid, gnd, b[i]);

    // INV -> AND2(a,b)
    pmos p_and (and_ab, vdd, nand_ab);
    nmos n_and (and_ab, gnd, nand_ab);

    // NOR2(a,b): series pull-ups, parallel pull-downs
    pmos p_nor_a (nor_ab_mid, vdd, a[i]);
    pmos p_nor_b (nor_ab, nor_ab_mid, b[i]);
    nmos n_nor_a (nor_ab, gnd, a[i]);
    nmos n_nor_b (nor_ab, gnd, b[i]);

    // INV -> OR2(a,b)
    pmos p_or (or_ab, vdd, nor_ab);
    nmos n_or (or_ab, gnd, nor_ab);

    // INV(AND2(a,b))
    pmos p_ninv (nand_n, vdd, and_ab);
    nmos n_ninv (nand_n, gnd, and_ab);

    // NAND2(or_ab, nand_n)
    pmos p_xn_a (nand_x, vdd, or_ab);
    pmos p_xn_b (nand_x, vdd, nand_n);
    nmos n_xn_a (nand_x, nand_x_mid, or_ab);
    nmos n_xn_b (nand_x_mid, gnd, nand_n);

    // INV -> XOR2
    pmos p_xor (xor_ab, vdd, nand_x);
    nmos n_xor (xor_ab, gnd, nand_x);

    assign sum_d[i]   = xor_ab;
    assign carry_d[i] = and_ab;
  end

`else

  assign sum_d   = a ^ b;
  assign carry_d = a & b;

`endif

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic             out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (in_valid) begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cmos_half_adder_reg.sv
// Self-checking bench for cmos_half_adder_reg (WIDTH = 4).
// A per-bit arithmetic model (a_i + b_i = 2*carry_i + sum_i) tracks the expected registered
// outputs; a negedge process compares the DUT against it every cycle after the first reset.
// Directed steps additionally check hand-computed literal values.

module tb_cmos_half_adder_reg;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             out_valid;

  int tests;
  int failed;

  cmos_half_adder_reg #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .sum      (sum),
    .carry    (carry),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Half addition as plain arithmetic: each bit pair adds to a 2-bit number {carry, sum}.
  function automatic logic [2*WIDTH-1:0] half_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    for (int i = 0; i < WIDTH; i++) begin
      int t;
      t    = int'(x[i]) + int'(y[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
    return {c, s};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model of the registered outputs.
  logic [WIDTH-1:0] m_sum;
  logic [WIDTH-1:0] m_carry;
  logic             m_valid;
  logic             m_known;

  initial m_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_sum   <= '0;
      m_carry <= '0;
      m_valid <= 1'b0;
      m_known <= 1'b1;
    end else if (m_known) begin
      m_valid <= in_valid;
      if (in_valid) {m_carry, m_sum} <= half_add(a, b);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("model_sum", 32'(sum), 32'(m_sum));
      check("model_carry", 32'(carry), 32'(m_carry));
      check("model_valid", 32'(out_valid), 32'(m_valid));
      check("no_x", 32'($isunknown({sum, carry, out_valid})), 32'd0);
    end
  end

  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] xa,
                      input logic [WIDTH-1:0] xb);
    rst      = r;
    in_valid = v;
    a        = xa;
    b        = xb;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [WIDTH-1:0] es,
                            input logic [WIDTH-1:0] ec, input logic ev);
    check({name, "_sum"}, 32'(sum), 32'(es));
    check({name, "_carry"}, 32'(carry), 32'(ec));
    check({name, "_valid"}, 32'(out_valid), 32'(ev));
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst = 1'b1; in_valid = 1'b1; a = '1; b = '1;

    // Pin the model itself with hand-computed values.
    check("model_pin_5_3", 32'(half_add(4'b0101, 4'b0011)), 32'h16);
    check("model_pin_f_f", 32'(half_add(4'hF, 4'hF)), 32'hF0);
    check("model_pin_a_5", 32'(half_add(4'hA, 4'h5)), 32'h0F);

    // Reset beats in_valid.
    step(1'b1, 1'b1, 4'hF, 4'hF);
    expect_out("reset1", 4'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'hF, 4'hF);
    expect_out("reset2", 4'h0, 4'h0, 1'b0);

    // Whole truth table in one vector.
    step(1'b0, 1'b1, 4'b0101, 4'b0011);
    expect_out("truth", 4'b0110, 4'b0001, 1'b1);

    // All ones then all zeros, back to back.
    step(1'b0, 1'b1, 4'hF, 4'hF);
    expect_out("ones", 4'h0, 4'hF, 1'b1);
    step(1'b0, 1'b1, 4'h0, 4'h0);
    expect_out("zeros", 4'h0, 4'h0, 1'b1);

    // Hold: outputs retain the last capture while in_valid is low.
    step(1'b0, 1'b1, 4'hA, 4'h5);
    expect_out("cap_a5", 4'hF, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'h3, 4'h3);
      expect_out("hold", 4'hF, 4'h0, 1'b0);
    end

    // Reset mid-stream discards the capture on that edge.
    step(1'b0, 1'b1, 4'h1, 4'h2);
    expect_out("stream", 4'h3, 4'h0, 1'b1);
    step(1'b1, 1'b1, 4'hC, 4'h4);
    expect_out("mid_rst", 4'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h6, 4'h3);
    expect_out("post_rst", 4'h5, 4'h2, 1'b1);

    // Exhaustive operand pairs, streamed back to back; checked by the model each cycle.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      step(1'b0, 1'b1, v[7:4], v[3:0]);
    end
    step(1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
